// File: rtl/rand_sched_pkg.sv
// Shared definitions for the random-value scheduler: register map, LFSR taps,
// CTRL bit positions and the LFSR step function.
package rand_sched_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_SEED     = 8'h04;
  localparam logic [7:0] ADDR_RAND     = 8'h08;
  localparam logic [7:0] ADDR_MASK     = 8'h0C;
  localparam logic [7:0] ADDR_STATUS   = 8'h10;
  localparam logic [7:0] ADDR_STCLR    = 8'h1C;
  localparam logic [7:0] ADDR_CNT_BASE = 8'h20;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_RESEED_BIT = 1;
  localparam int STATUS_ANY_BIT  = 8;

  typedef logic [2:0] req_id_t;

  // Right-shifting Galois step
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // The LFSR must never hold the all-zero lock-up state
  function automatic logic [31:0] lfsr_nonzero(input logic [31:0] v);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

endpackage

// File: rtl/rand_sched_arb.sv
// Combinational round-robin picker: first requester at or after ptr that is
// both requesting and unmasked; one-hot grant plus its index.
module rr_arbiter
  import rand_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  req_id_t         ptr,
  output logic [NREQ-1:0] gnt,
  output req_id_t         id,
  output logic            vld
);

  logic [7:0] elig8;
  logic [3:0] idx;

  always_comb begin
    elig8 = 8'(req & mask);
    vld   = 1'b0;
    id    = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 4'(ptr) + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!vld && elig8[idx[2:0]]) begin
        vld = 1'b1;
        id  = idx[2:0];
      end
    end
    gnt = '0;
    for (int i = 0; i < NREQ; i++) gnt[i] = vld && (id == 3'(i));
  end

endmodule

// File: rtl/rand_sched.sv
// APB-controlled random-number scheduler: one Galois LFSR shared by NREQ
// hardware requesters (round-robin) and CPU RAND reads. Per-requester grant
// counters are built only when RAND_SCHED_STATS_EN is defined.
module rand_sched
  import rand_sched_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter logic [31:0] LFSR_RST = 32'hACE1ACE1
) (
  input  logic            PCLK,
  input  logic            PRESETN,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [7:0]      PADDR,
  input  logic [31:0]     PWDATA,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rdata
);

  logic        rd_acc, wr_acc;
  logic        rand_rd, seed_wr, ctrl_wr, mask_wr, status_rd, reseed;
  logic [31:0] lfsr_q, cyc_q, prdata, stat_rdata;
  logic        ctrl_en_q;
  logic [NREQ-1:0] mask_q, arb_req, arb_gnt;
  req_id_t     ptr_q, arb_id, status_id_q;
  logic        arb_vld, take, status_any_q;
  logic [NREQ-1:0] gnt_p1;
  logic [31:0] rdata_p1;

  assign rd_acc    = PSEL && PENABLE && !PWRITE;
  assign wr_acc    = PSEL && PENABLE && PWRITE;
  assign rand_rd   = rd_acc && (PADDR == ADDR_RAND);
  assign status_rd = rd_acc && (PADDR == ADDR_STATUS);
  assign seed_wr   = wr_acc && (PADDR == ADDR_SEED);
  assign ctrl_wr   = wr_acc && (PADDR == ADDR_CTRL);
  assign mask_wr   = wr_acc && (PADDR == ADDR_MASK);
  assign reseed    = ctrl_wr && PWDATA[CTRL_RESEED_BIT];

  // A requester granted last cycle sits out one cycle before it is eligible again
  assign arb_req = req & ~gnt_p1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (arb_req),
    .mask (mask_q),
    .ptr  (ptr_q),
    .gnt  (arb_gnt),
    .id   (arb_id),
    .vld  (arb_vld)
  );

  // A CPU RAND read owns the LFSR this cycle, so hardware waits
  assign take = arb_vld && ctrl_en_q && !rand_rd;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      lfsr_q       <= LFSR_RST;
      cyc_q        <= '0;
      ctrl_en_q    <= 1'b0;
      mask_q       <= '1;
      ptr_q        <= '0;
      status_id_q  <= '0;
      status_any_q <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (seed_wr)                lfsr_q <= lfsr_nonzero(PWDATA);
      else if (reseed)            lfsr_q <= lfsr_nonzero(lfsr_q ^ cyc_q);
      else if (take || rand_rd)   lfsr_q <= lfsr_next(lfsr_q);
      if (ctrl_wr) ctrl_en_q <= PWDATA[CTRL_EN_BIT];
      if (mask_wr) mask_q    <= PWDATA[NREQ-1:0];
      if (take) begin
        ptr_q        <= (arb_id == req_id_t'(NREQ-1)) ? '0 : arb_id + 3'd1;
        status_id_q  <= arb_id;
        status_any_q <= 1'b1;
      end else if (status_rd) begin
        status_any_q <= 1'b0;
      end
    end
  end

  // Stage p1: registered grant with the pre-advance LFSR value
  always_ff @(posedge PCLK) begin
    if (!PRESETN) gnt_p1 <= '0;
    else          gnt_p1 <= take ? arb_gnt : '0;
  end

  always_ff @(posedge PCLK) begin
    if (take) rdata_p1 <= lfsr_q;
  end

`ifdef RAND_SCHED_STATS_EN
  logic [15:0] cnt_q [8];
  logic        stat_clr;
  logic [7:0]  cnt_off;

  assign stat_clr = wr_acc && (PADDR == ADDR_STCLR);
  assign cnt_off  = PADDR - ADDR_CNT_BASE;

  always_ff @(posedge PCLK) begin
    for (int i = 0; i < 8; i++) begin
      if (!PRESETN || stat_clr)
        cnt_q[i] <= '0;
      else if (take && arb_id == 3'(i) && cnt_q[i] != 16'hFFFF)
        cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    stat_rdata = '0;
    if (cnt_off[1:0] == 2'b00 && cnt_off[7:2] < 6'(NREQ))
      stat_rdata[15:0] = cnt_q[cnt_off[4:2]];
  end
`else
  assign stat_rdata = '0;
`endif

  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      case (PADDR)
        ADDR_CTRL:   prdata[CTRL_EN_BIT] = ctrl_en_q;
        ADDR_SEED:   prdata = '0;
        ADDR_RAND:   prdata = lfsr_q;
        ADDR_MASK:   prdata[NREQ-1:0] = mask_q;
        ADDR_STATUS: begin
          prdata[2:0]            = status_id_q;
          prdata[STATUS_ANY_BIT] = status_any_q;
        end
        default:     prdata = stat_rdata;
      endcase
    end
  end

  assign PRDATA  = prdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign gnt     = gnt_p1;
  assign rdata   = rdata_p1;

endmodule
